// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider front-end sequencer.
// Holds the FSM state encoding, the default datapath width, and the
// constants used for the divide-by-zero shortcut result.
package div_sequencer_pkg;

    // Default operand/result width; must match the divider datapath.
    localparam int DIV_WIDTH = 32;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Divide-by-zero returns a quotient with every bit set to this value and
    // passes the raw dividend through as the remainder.
    localparam logic DIV0_Q_FILL = 1'b1;

endpackage : div_sequencer_pkg

// File: rtl/div_sign_fix.sv
// Combinational magnitude / negate helper.
// Returns the two's-complement negation of value when negate is set,
// otherwise value unchanged (arithmetic is modulo 2^WIDTH).
// Ports:
//   value  - input operand
//   negate - 1 = return -value
//   result - conditioned output
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Conditional two's-complement negate.
    always_comb begin
        result = value;
        if (negate) begin
            result = ~value + ONE;
        end else begin
            result = value;
        end
    end

endmodule : div_sign_fix

// File: rtl/div_sequencer.sv
// Front-end sequencer for the multi-cycle unsigned divider.
// Accepts signed/unsigned divide requests, feeds operand magnitudes to the
// divider through its load/run/ready protocol, sign-corrects the result and
// holds it until the consumer accepts it. Divide-by-zero and signed overflow
// are answered directly; a watchdog aborts a hung divider with Resp_err.
// Ports:
//   clk, Reset                         - clock, synchronous active-high reset
//   Req_valid/Req_ready/Req_signed,
//   Req_dividend/Req_divisor           - request handshake and operands
//   Resp_valid/Resp_ready/Resp_quotient,
//   Resp_remainder/Resp_err            - response handshake and results
//   Div_load/Div_run/Div_dividend,
//   Div_divisor                        - control and operands to the divider
//   Div_ready/Div_quotient/Div_remainder - divider status and raw results
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Req_valid,
    output logic             Req_ready,
    input  logic             Req_signed,
    input  logic [WIDTH-1:0] Req_dividend,
    input  logic [WIDTH-1:0] Req_divisor,
    output logic             Resp_valid,
    input  logic             Resp_ready,
    output logic [WIDTH-1:0] Resp_quotient,
    output logic [WIDTH-1:0] Resp_remainder,
    output logic             Resp_err,
    output logic             Div_load,
    output logic             Div_run,
    output logic [WIDTH-1:0] Div_dividend,
    output logic [WIDTH-1:0] Div_divisor,
    input  logic             Div_ready,
    input  logic [WIDTH-1:0] Div_quotient,
    input  logic [WIDTH-1:0] Div_remainder
);

    localparam int               WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_ZERO  = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]  WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DIV0_Q   = {WIDTH{DIV0_Q_FILL}};

    state_e           state_r;
    state_e           state_nxt_s;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic             resp_err_r;
    logic             div_load_r;
    logic             div_run_r;
    logic [WIDTH-1:0] resp_quotient_r;
    logic [WIDTH-1:0] resp_remainder_r;
    logic [WIDTH-1:0] div_dividend_r;
    logic [WIDTH-1:0] div_divisor_r;
    logic [WIDTH-1:0] q_raw_r;
    logic [WIDTH-1:0] r_raw_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WD_W-1:0]  wdog_r;

    logic             accept_s;
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic             ready_hit_s;
    logic             timeout_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    assign Req_ready      = req_ready_r;
    assign Resp_valid     = resp_valid_r;
    assign Resp_err       = resp_err_r;
    assign Resp_quotient  = resp_quotient_r;
    assign Resp_remainder = resp_remainder_r;
    assign Div_load       = div_load_r;
    assign Div_run        = div_run_r;
    assign Div_dividend   = div_dividend_r;
    assign Div_divisor    = div_divisor_r;

    assign accept_s    = Req_valid & req_ready_r & (state_r == ST_IDLE);
    assign dvd_neg_s   = Req_signed & Req_dividend[WIDTH-1];
    assign dvs_neg_s   = Req_signed & Req_divisor[WIDTH-1];
    assign div_zero_s  = (Req_divisor == ZERO);
    assign overflow_s  = Req_signed & (Req_dividend == MOST_NEG) & (Req_divisor == ALL_ONES);
    // The first RUN cycle (watchdog still 0) sees the previous operation's
    // Ready level, so it must not be trusted.
    assign ready_hit_s = Div_ready & (wdog_r != WD_ZERO);
    assign timeout_s   = (wdog_r == WD_LAST);

    div_sign_fix #(.WIDTH(WIDTH)) u_dvd_mag (.value(Req_dividend), .negate(dvd_neg_s), .result(dvd_mag_s));
    div_sign_fix #(.WIDTH(WIDTH)) u_dvs_mag (.value(Req_divisor),  .negate(dvs_neg_s), .result(dvs_mag_s));
    div_sign_fix #(.WIDTH(WIDTH)) u_q_fix   (.value(q_raw_r),      .negate(neg_q_r),   .result(q_fix_s));
    div_sign_fix #(.WIDTH(WIDTH)) u_r_fix   (.value(r_raw_r),      .negate(neg_r_r),   .result(r_fix_s));

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (div_zero_s || overflow_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (ready_hit_s) begin
                    state_nxt_s = ST_FIX;
                end else if (timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (Resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and handshake/control outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            div_load_r   <= 1'b0;
            div_run_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_DONE);
            div_load_r   <= (state_nxt_s == ST_LOAD);
            div_run_r    <= (state_nxt_s == ST_RUN);
        end
    end

    // Watchdog: counts RUN cycles from 0, cleared in every other state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wdog_r <= WD_ZERO;
        end else if (state_r == ST_RUN) begin
            wdog_r <= wdog_r + WD_ONE;
        end else begin
            wdog_r <= WD_ZERO;
        end
    end

    // Operand latch, raw result capture and response registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            div_dividend_r   <= ZERO;
            div_divisor_r    <= ZERO;
            neg_q_r          <= 1'b0;
            neg_r_r          <= 1'b0;
            q_raw_r          <= ZERO;
            r_raw_r          <= ZERO;
            resp_quotient_r  <= ZERO;
            resp_remainder_r <= ZERO;
            resp_err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        div_dividend_r <= dvd_mag_s;
                        div_divisor_r  <= dvs_mag_s;
                        neg_q_r        <= dvd_neg_s ^ dvs_neg_s;
                        neg_r_r        <= dvd_neg_s;
                        resp_err_r     <= 1'b0;
                        if (div_zero_s) begin
                            resp_quotient_r  <= DIV0_Q;
                            resp_remainder_r <= Req_dividend;
                        end else if (overflow_s) begin
                            resp_quotient_r  <= MOST_NEG;
                            resp_remainder_r <= ZERO;
                        end
                    end
                end
                ST_RUN: begin
                    if (ready_hit_s) begin
                        q_raw_r <= Div_quotient;
                        r_raw_r <= Div_remainder;
                    end else if (timeout_s) begin
                        resp_quotient_r  <= ZERO;
                        resp_remainder_r <= ZERO;
                        resp_err_r       <= 1'b1;
                    end
                end
                ST_FIX: begin
                    resp_quotient_r  <= q_fix_s;
                    resp_remainder_r <= r_fix_s;
                end
                ST_DONE: begin
                    if (Resp_ready) begin
                        resp_err_r <= 1'b0;
                    end
                end
                default: begin
                    resp_err_r <= 1'b0;
                end
            endcase
        end
    end

endmodule : div_sequencer

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Front-end sequencer for the multi-cycle unsigned 32-bit divider.
- Accepts signed or unsigned divide requests over a valid/ready handshake and converts operands to magnitudes.
- Drives the divider's load/run/ready protocol, then sign-corrects quotient and remainder and holds the result until the consumer accepts it.
- Handles divide-by-zero and signed overflow without invoking the divider, and detects a hung divider with a watchdog.

Parameters:
- WIDTH, 32, operand/result width; must match the divider datapath.
- TIMEOUT, 40, maximum cycles in RUN before the operation is aborted with Resp_err.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req_valid  input  1  request present.
- Req_ready  output  1  sequencer can accept a request; high only in IDLE.
- Req_signed  input  1  1 = signed divide, 0 = unsigned.
- Req_dividend  input  WIDTH  dividend.
- Req_divisor  input  WIDTH  divisor.
- Resp_valid  output  1  result available.
- Resp_ready  input  1  consumer accepts the result.
- Resp_quotient  output  WIDTH  final quotient.
- Resp_remainder  output  WIDTH  final remainder.
- Resp_err  output  1  watchdog timeout occurred; results are 0.
- Div_load  output  1  one-cycle pulse to the divider's Reset input; loads the operands.
- Div_run  output  1  held high while the divider iterates.
- Div_dividend  output  WIDTH  magnitude of the dividend to the divider.
- Div_divisor  output  WIDTH  magnitude of the divisor to the divider.
- Div_ready  input  1  divider finished (level).
- Div_quotient  input  WIDTH  unsigned quotient from the divider.
- Div_remainder  input  WIDTH  unsigned remainder from the divider.

Behaviour:
- Reset, regardless of state (including mid-operation):
  - State goes to IDLE.
  - Req_ready=1 from the following cycle.
  - Resp_valid=0, Resp_err=0, Div_load=0, Div_run=0.
  - Resp_quotient, Resp_remainder, Div_dividend and Div_divisor all 0; watchdog counter cleared.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE:
  - On Req_valid and Req_ready, latch operands and the signed flag. Record neg_q = signed & (dividend[MSB] ^ divisor[MSB]) and neg_r = signed & dividend[MSB].
  - If divisor==0: quotient=all ones, remainder=dividend (raw, unmodified); go to DONE.
  - Else if signed and dividend==1<<(WIDTH-1) and divisor==all ones: quotient=1<<(WIDTH-1), remainder=0; go to DONE.
  - Otherwise drive the magnitudes onto Div_dividend/Div_divisor (two's-complement negate when signed and negative) and go to LOAD.
- LOAD: Div_load=1 for exactly one cycle; Div_run=0; go to RUN.
- RUN:
  - Div_run=1 and the watchdog counts up from 0.
  - Div_ready is ignored in the first RUN cycle, which masks the stale Ready left over from the previous operation.
  - From the second RUN cycle, Div_ready=1 captures Div_quotient/Div_remainder and goes to FIX.
  - If the count reaches TIMEOUT before that: Resp_err=1, results 0, go to DONE.
  - Div_run drops to 0 on exit.
- FIX (one cycle):
  - Resp_quotient = neg_q ? -q : q.
  - Resp_remainder = neg_r ? -r : r.
  - Go to DONE.
- DONE:
  - Resp_valid=1 with outputs stable until Resp_ready.
  - On Resp_valid & Resp_ready, go to IDLE; Resp_valid and Resp_err clear next cycle.
  - No new request is accepted in the same cycle as the response (Req_ready=0 in DONE).
- Latency: the divider path takes acceptance + 1 (LOAD) + N run cycles + 1 (FIX) before Resp_valid. Special cases reach Resp_valid the cycle after acceptance.
- Div_dividend/Div_divisor hold their values from acceptance until the next acceptance.
- Arithmetic is modulo 2^WIDTH; the magnitude of the most negative value is 1<<(WIDTH-1) as unsigned, which is correct.
- Req_valid while not in IDLE is ignored; the requester must hold it.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=0, LOAD=1, RUN=2, FIX=3, DONE=4, 3 bits).
  - WIDTH default.
  - The divide-by-zero constants.
- One natural sub-module, div_sign_fix: a combinational magnitude/negate helper, instantiated for operand conditioning and for result correction.
- FSM, watchdog and response registers stay in div_sequencer.

Test Plan:
- Unsigned: 100/7 -> Div_load pulse, Div_run until Div_ready; Resp_quotient=14, Resp_remainder=2, Resp_err=0.
- Signed: -100/7 -> Div_dividend=100; Resp_quotient=0xFFFFFFF2 (-14), Resp_remainder=0xFFFFFFFE (-2). Signed 100/-7 -> quotient -14, remainder 2.
- Divide by zero, signed: 0x12345678/0 -> no Div_load; Resp_valid one cycle after acceptance; quotient 0xFFFFFFFF, remainder 0x12345678.
- Overflow: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, no Div_load.
- Backpressure and timeout:
  - Hold Resp_ready=0 for 5 cycles -> outputs stable and Req_ready=0 throughout.
  - Tie Div_ready=0 -> Resp_err=1 after TIMEOUT RUN cycles, with results 0.
- Reset asserted in the middle of RUN -> next cycle IDLE, Div_run=0, Resp_valid=0. A following 9/3 request yields quotient 3, remainder 0.
